// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit: BTB entry layout,
// 2-bit counter encodings and the prefetch FIFO payload.
package ifu_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Tag is stored right-aligned; bits above the real tag width are always zero.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] tag;
    logic [XLEN-1:0] target;
    logic [1:0]      ctr;
  } btb_entry_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_pair_t;

  function automatic logic [XLEN-1:0] btb_tag(input logic [XLEN-1:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == CTR_ST) ? CTR_ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == CTR_SNT) ? CTR_SNT : c - 2'd1;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Single-beat instruction memory port: the fetch unit is master, memory is slave.
interface instruction_fetch_unit_if;
  import ifu_pkg::*;

  logic [XLEN-1:0] mem_addr;
  logic            mem_read;
  logic [XLEN-1:0] mem_data;
  logic            mem_ready;

  modport master (output mem_addr, output mem_read, input mem_data, input mem_ready);
  modport slave  (input mem_addr, input mem_read, output mem_data, output mem_ready);
endinterface

// File: rtl/ifu_prefetch_fifo.sv
// Prefetch FIFO of {pc, instr} pairs with registered occupancy and synchronous flush.
// Reset input is active-high despite its name.
module ifu_prefetch_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  fetch_pair_t push_data,
  input  logic        pop,
  output fetch_pair_t head,
  output logic        full,
  output logic        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_q, rd_q;
  logic [CNT_W-1:0] cnt_q;
  fetch_pair_t      mem_q [DEPTH];
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_q];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PTR_W'(1);
      if (do_pop)  rd_q <= rd_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // NOTE: storage is not reset; the occupancy count guarantees no stale entry is ever read.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: fetch PC, prefetch FIFO and optional BTB/2-bit predictor.
// Predictor is built only when IFU_BRANCH_PREDICT_EN is defined.
module instruction_fetch_unit
  import ifu_pkg::*;
#(
  parameter int              FIFO_DEPTH  = 4,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  instruction_fetch_unit_if.master   mem,
  output logic [XLEN-1:0]            instruction,
  output logic [XLEN-1:0]            instruction_pc,
  output logic                       instruction_valid,
  input  logic                       fetch_next,
  input  logic                       branch_resolved,
  input  logic                       branch_taken,
  input  logic [XLEN-1:0]            branch_pc,
  input  logic [XLEN-1:0]            branch_target,
  input  logic                       stall,
  output logic                       prefetch_full,
  output logic                       prefetch_empty,
  output logic                       prediction_valid,
  output logic                       prediction,
  output logic [XLEN-1:0]            predicted_target,
  output logic [XLEN-1:0]            current_fetch_pc
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] next_pc;
  logic            fifo_full, fifo_empty;
  logic            push, pop, mispredict;
  fetch_pair_t     head;

`ifdef IFU_BRANCH_PREDICT_EN
  localparam int IDX_W = $clog2(BTB_ENTRIES);

  btb_entry_t       btb_q [BTB_ENTRIES];
  logic [IDX_W-1:0] f_idx, r_idx;
  btb_entry_t       f_ent, r_ent;
  logic             f_hit, r_hit, r_pred_taken;

  assign f_idx = fetch_pc_q[IDX_W+1:2];
  assign r_idx = branch_pc[IDX_W+1:2];
  assign f_ent = btb_q[f_idx];
  assign r_ent = btb_q[r_idx];
  assign f_hit = f_ent.valid && (f_ent.tag == btb_tag(fetch_pc_q, IDX_W));
  assign r_hit = r_ent.valid && (r_ent.tag == btb_tag(branch_pc, IDX_W));

  assign prediction_valid = f_hit;
  assign prediction       = f_hit && (f_ent.ctr inside {CTR_WT, CTR_ST});
  assign predicted_target = f_hit ? f_ent.target : '0;
  assign next_pc          = prediction ? f_ent.target : fetch_pc_q + XLEN'(4);

  assign r_pred_taken = r_hit && (r_ent.ctr inside {CTR_WT, CTR_ST});
  assign mispredict   = branch_resolved &&
                        ((branch_taken != r_pred_taken) ||
                         (branch_taken && r_pred_taken && (r_ent.target != branch_target)));

  // Valid bits and counters need defined values, so the whole table is reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (branch_resolved) begin
      if (branch_taken) begin
        if (r_hit) begin
          btb_q[r_idx].ctr    <= ctr_inc(r_ent.ctr);
          btb_q[r_idx].target <= branch_target;
        end else begin
          btb_q[r_idx] <= '{valid: 1'b1, tag: btb_tag(branch_pc, IDX_W),
                            target: branch_target, ctr: CTR_WT};
        end
      end else if (r_hit) begin
        btb_q[r_idx].ctr <= ctr_dec(r_ent.ctr);
      end
    end
  end
`else
  assign prediction_valid = 1'b0;
  assign prediction       = 1'b0;
  assign predicted_target = '0;
  assign next_pc          = fetch_pc_q + XLEN'(4);
  // Without a predictor every fall-through guess is wrong exactly when the branch is taken.
  assign mispredict       = branch_resolved && branch_taken;
`endif

  assign mem.mem_addr = fetch_pc_q;
  assign mem.mem_read = !rst_n && !stall && !fifo_full && !mispredict;
  assign push         = mem.mem_read && mem.mem_ready;
  assign pop          = fetch_next && !fifo_empty && !stall && !mispredict;

  // NOTE: default assignment first so no path through the block can infer a latch.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (mispredict) begin
      fetch_pc_d = branch_taken ? branch_target : branch_pc + XLEN'(4);
    end else if (push) begin
      fetch_pc_d = next_pc;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) fetch_pc_q <= RESET_PC;
    else       fetch_pc_q <= fetch_pc_d;
  end

  ifu_prefetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (mispredict),
    .push      (push),
    .push_data ('{pc: fetch_pc_q, instr: mem.mem_data}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign instruction       = fifo_empty ? '0 : head.instr;
  assign instruction_pc    = fifo_empty ? '0 : head.pc;
  assign instruction_valid = !fifo_empty;
  assign prefetch_full     = fifo_full;
  assign prefetch_empty    = fifo_empty;
  assign current_fetch_pc  = fetch_pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: cycle model with a scoreboard queue of expected
// FIFO heads; BTB expectations follow IFU_BRANCH_PREDICT_EN.
module tb_instruction_fetch_unit;

  localparam int          FIFO_DEPTH = 4;
  localparam logic [31:0] MEM_OFS    = 32'hA0A0A0A0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction, instruction_pc, branch_pc, branch_target;
  logic [31:0] predicted_target, current_fetch_pc;
  logic        instruction_valid, fetch_next, branch_resolved, branch_taken, stall;
  logic        prefetch_full, prefetch_empty, prediction_valid, prediction;

  instruction_fetch_unit_if mem_if ();

  assign mem_if.mem_data = mem_if.mem_addr + MEM_OFS;

  instruction_fetch_unit #(.FIFO_DEPTH(FIFO_DEPTH), .BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .mem               (mem_if),
    .instruction       (instruction),
    .instruction_pc    (instruction_pc),
    .instruction_valid (instruction_valid),
    .fetch_next        (fetch_next),
    .branch_resolved   (branch_resolved),
    .branch_taken      (branch_taken),
    .branch_pc         (branch_pc),
    .branch_target     (branch_target),
    .stall             (stall),
    .prefetch_full     (prefetch_full),
    .prefetch_empty    (prefetch_empty),
    .prediction_valid  (prediction_valid),
    .prediction        (prediction),
    .predicted_target  (predicted_target),
    .current_fetch_pc  (current_fetch_pc)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_pc;
  pair_t       q[$];
  logic        m_v   [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];
  logic [1:0]  m_ctr [16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    q.delete();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 2'b01;
    end
  endtask

  function automatic void lookup(input logic [31:0] pc, output logic hit,
                                 output logic [1:0] ctr, output logic [31:0] tgt);
    int unsigned i;
    i   = (pc >> 2) & 32'hF;
    hit = m_v[i] && (m_tag[i] == (pc >> 6));
    ctr = m_ctr[i];
    tgt = m_tgt[i];
`ifndef IFU_BRANCH_PREDICT_EN
    hit = 1'b0;
`endif
  endfunction

  // Called just after a falling edge with inputs settled; returns after the next falling edge.
  task automatic cycle();
    logic        hit_f, hit_r, full, empty, pred, rpred, mis, mread, push, pop;
    logic [1:0]  ctr_f, ctr_r;
    logic [31:0] tgt_f, tgt_r;
    int unsigned i;
    #1;
    lookup(m_pc, hit_f, ctr_f, tgt_f);
    lookup(branch_pc, hit_r, ctr_r, tgt_r);
    full  = (q.size() == FIFO_DEPTH);
    empty = (q.size() == 0);
    pred  = hit_f && ctr_f[1];
    rpred = hit_r && ctr_r[1];
    mis   = branch_resolved && ((branch_taken != rpred) ||
                                (branch_taken && rpred && (tgt_r != branch_target)));
    mread = !stall && !full && !mis;
    push  = mread && mem_if.mem_ready;
    pop   = fetch_next && !empty && !stall && !mis;

    check("mem_addr", mem_if.mem_addr, m_pc);
    check("fetch_pc", current_fetch_pc, m_pc);
    check("mem_read", mem_if.mem_read, mread);
    check("full", prefetch_full, full);
    check("empty", prefetch_empty, empty);
    check("valid", instruction_valid, !empty);
    check("head_pc", instruction_pc, empty ? 32'h0 : q[0].pc);
    check("head_instr", instruction, empty ? 32'h0 : q[0].instr);
    check("pred_valid", prediction_valid, hit_f);
    check("pred", prediction, pred);
    check("pred_target", predicted_target, hit_f ? tgt_f : 32'h0);

    @(posedge clk);
    if (mis) begin
      q.delete();
      m_pc = branch_taken ? branch_target : branch_pc + 32'd4;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{pc: m_pc, instr: m_pc + MEM_OFS});
        m_pc = pred ? tgt_f : m_pc + 32'd4;
      end
    end
    if (branch_resolved) begin
      i = (branch_pc >> 2) & 32'hF;
      if (branch_taken) begin
        if (hit_r) begin
          m_ctr[i] = (ctr_r == 2'b11) ? 2'b11 : ctr_r + 2'd1;
          m_tgt[i] = branch_target;
        end else begin
          m_v[i] = 1'b1; m_tag[i] = branch_pc >> 6; m_tgt[i] = branch_target; m_ctr[i] = 2'b10;
        end
      end else if (hit_r) begin
        m_ctr[i] = (ctr_r == 2'b00) ? 2'b00 : ctr_r - 2'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic resolve(input logic taken, input logic [31:0] pc, input logic [31:0] tgt);
    branch_resolved = 1'b1; branch_taken = taken; branch_pc = pc; branch_target = tgt;
    cycle();
    branch_resolved = 1'b0; branch_taken = 1'b0; branch_pc = '0; branch_target = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, mem_if.mem_addr, 32'h0);
    check({tag, "_read"}, mem_if.mem_read, 1'b0);
    check({tag, "_empty"}, prefetch_empty, 1'b1);
    check({tag, "_valid"}, instruction_valid, 1'b0);
    check({tag, "_instr"}, instruction, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  initial begin
    pair_t       head0;
    logic [31:0] pc_before;
    rst_n = 1'b1; fetch_next = 1'b0; branch_resolved = 1'b0; branch_taken = 1'b0;
    branch_pc = '0; branch_target = '0; stall = 1'b0; mem_if.mem_ready = 1'b1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Streaming fetch with decode consuming every cycle.
    fetch_next = 1'b1;
    run(6);

    // Fill without consumption.
    fetch_next = 1'b0;
    do_reset();
    run(6);
    check("full_flag", prefetch_full, 1'b1);
    check("full_read", mem_if.mem_read, 1'b0);
    check("full_addr", mem_if.mem_addr, 32'h10);

    // Taken branch with an empty BTB redirects and flushes.
    resolve(1'b1, 32'h20, 32'h100);
    check("redir_empty", prefetch_empty, 1'b1);
    check("redir_addr", mem_if.mem_addr, 32'h100);
    cycle();
    head0 = '{pc: 32'h100, instr: 32'hA0A0A1A0};
    check("redir_head_pc", instruction_pc, head0.pc);
    check("redir_head_instr", instruction, head0.instr);

    // Walk back up to the trained branch.
    fetch_next = 1'b1;
    resolve(1'b1, 32'h200, 32'h10);
    run(4);
`ifdef IFU_BRANCH_PREDICT_EN
    check("btb_hit", prediction_valid, 1'b1);
    check("btb_pred", prediction, 1'b1);
    check("btb_target", predicted_target, 32'h100);
`else
    check("btb_hit", prediction_valid, 1'b0);
`endif
    cycle();
`ifdef IFU_BRANCH_PREDICT_EN
    check("pred_fetch", mem_if.mem_addr, 32'h100);
`else
    check("pred_fetch", mem_if.mem_addr, 32'h24);
`endif
    check("pred_noflush", prefetch_empty, 1'b0);

    // Stall freezes fetch and consumption.
    pc_before = m_pc;
    stall = 1'b1;
    run(3);
    check("stall_pc", current_fetch_pc, pc_before);
    stall = 1'b0;
    run(3);

    // Not-taken and retargeted resolutions of the trained branch.
    resolve(1'b0, 32'h20, 32'h0);
    run(2);
    resolve(1'b1, 32'h20, 32'h40);
    run(2);

    // Randomised traffic: back-pressure, stalls, memory not ready, resolutions.
    for (int k = 0; k < 80; k++) begin
      fetch_next       = ($urandom_range(0, 3) != 0);
      stall            = ($urandom_range(0, 7) == 0);
      mem_if.mem_ready = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 4) == 0) begin
        branch_resolved = 1'b1;
        branch_taken    = $urandom_range(0, 1) == 1;
        case ($urandom_range(0, 3))
          0: branch_pc = 32'h20;
          1: branch_pc = 32'h24;
          2: branch_pc = 32'h100;
          default: branch_pc = 32'h60;
        endcase
        branch_target = ($urandom_range(0, 1) == 1) ? 32'h100 : 32'h40;
      end else begin
        branch_resolved = 1'b0; branch_taken = 1'b0; branch_pc = '0; branch_target = '0;
      end
      cycle();
    end
    branch_resolved = 1'b0; branch_taken = 1'b0; branch_pc = '0; branch_target = '0;
    stall = 1'b0; mem_if.mem_ready = 1'b1; fetch_next = 1'b1;
    run(2);

    // Asynchronous reset in the middle of a cycle.
    #2;
    rst_n = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("async");
    check("async_pc", current_fetch_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    run(8);
    check("btb_cleared", prediction_valid, 1'b0);
    check("btb_cleared_pc", current_fetch_pc, 32'h20);
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Front-end instruction fetch stage: owns the fetch PC and reads 32-bit instructions from instruction memory through a single-beat request/ready port. It queues fetched {PC, instruction} pairs in a small prefetch FIFO for the decode stage. A BTB with 2-bit counters predicts the next fetch address, and resolved branches from execute update the predictor and redirect fetch on a misprediction.

## Interface
- FIFO_DEPTH, 4: prefetch FIFO entries (power of two, ≥2)
- BTB_ENTRIES, 16: direct-mapped BTB/BHT entries (power of two)
- RESET_PC, 32'h0: fetch PC after reset
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, asynchronous, active-high (1 = reset)
- mem_addr  out  32  fetch address, always equal to fetch PC
- mem_read  out  1  fetch request
- mem_data  in  32  instruction word, valid when mem_ready=1
- mem_ready  in  1  memory response in the same cycle as mem_read
- instruction  out  32  FIFO head instruction, 0 when empty
- instruction_pc  out  32  FIFO head PC, 0 when empty
- instruction_valid  out  1  FIFO not empty
- fetch_next  in  1  decode consumes the head
- branch_resolved  in  1  branch outcome valid this cycle
- branch_taken  in  1  resolved direction
- branch_pc  in  32  resolved branch address
- branch_target  in  32  resolved taken target
- stall  in  1  freeze fetch and consumption
- prefetch_full / prefetch_empty  out  1  FIFO status
- prediction_valid  out  1  BTB hit for current_fetch_pc
- prediction  out  1  predicted taken (counter MSB)
- predicted_target  out  32  BTB target, 0 on a miss
- current_fetch_pc  out  32  fetch PC register

## Operation
- Index = pc[log2(BTB_ENTRIES)+1:2]. Tag = the remaining upper PC bits. Each entry holds {valid, tag, target, 2-bit counter}.
- mem_read = !rst_n_asserted && !stall && !prefetch_full && !branch_resolved_mispredict.
- Push when mem_read && mem_ready: {fetch_pc, mem_data} enters the FIFO.
- Next PC = predicted_target if prediction_valid && prediction, else fetch_pc+4. Addition wraps mod 2^32.
- Pop when fetch_next && instruction_valid && !stall.
- Resolution lookup uses branch_pc before the update. The branch is mispredicted if branch_taken differs from (hit && counter[1]), or if it is taken with hit && counter[1] and stored target ≠ branch_target.
- Mispredict: flush the FIFO and set fetch_pc to branch_taken ? branch_target : branch_pc+4. This overrides stall, push and pop in that cycle.
- Predictor update:
  - Taken and hit: counter increments (saturating), target rewritten.
  - Taken and miss: allocate the entry with valid=1, tag, target, counter=2'b10.
  - Not taken and hit: counter decrements (saturating at 0).
  - Not taken and miss: no change.
- Reset state: fetch_pc=RESET_PC, FIFO empty, all BTB valid bits 0, counters 2'b01. All outputs follow from this state: prefetch_empty=1, instruction_valid=0, mem_addr=RESET_PC.

## Timing
- Zero-wait memory: a request and its push happen at the same clock edge. A pushed word is visible at the head one cycle later.
- Full FIFO blocks the request even if a pop occurs in the same cycle (full is registered). Push and pop in the same cycle on a non-full FIFO are allowed.
- Flush takes effect at the next edge. The first fetch from the new PC is issued in the following cycle.
- Reset assertion clears all state immediately, without waiting for a clock edge.

## Configuration
- IFU_BRANCH_PREDICT_EN defined: BTB/BHT present as described above.
- IFU_BRANCH_PREDICT_EN undefined: no predictor storage. prediction_valid, prediction and predicted_target are tied to 0, and next PC is always fetch_pc+4. Every taken resolution is a mispredict; not-taken resolutions never redirect.

## Structure
- Package ifu_pkg holds the BTB entry struct, the counter encodings (SNT=00, WNT=01, WT=10, ST=11) and the XLEN=32 constant.
- One sub-module, ifu_prefetch_fifo, stores {pc, instr} pairs and provides full/empty, push/pop and synchronous flush.

## Test plan
- Reset, then fetch_next=1 → heads in order (0x0, 0xA0A0A0A0), (0x4, 0xA0A0A0A4), (0x8, 0xA0A0A0A8), with memory returning addr+0xA0A0A0A0.
- fetch_next=0 from reset → prefetch_full=1 after 4 pushes, mem_read=0, mem_addr=0x10 held.
- Empty BTB, branch_resolved with taken, pc 0x20, target 0x100 → next cycle FIFO empty, mem_addr=0x100. Next head is (0x100, 0xA0A0A1A0).
- After that training, fetch reaches 0x20 → prediction_valid=1, prediction=1, predicted_target=0x100, next fetch at 0x100 without a flush.
- stall=1 for 3 cycles → mem_read=0, FIFO contents and fetch PC unchanged, no pops. Fetching resumes on release.
- rst_n asserted mid-fetch → outputs return to reset values immediately and the BTB is invalidated.
